// File: rtl/ysyx_23060203_csu.sv
// ysyx_23060203_csu -- control-status unit for writeback/branch redirects.
//
// This unit takes a flush request from writeback (CSR write, trap, xRET or
// fence.i) or a mispredict redirect from execute. It kills younger in-flight
// work and, for fence.i, waits for the LSU to drain and then runs an I-cache
// invalidate. It then offers the new fetch PC to the IFU over a
// valid/ready handshake.
//
// Configuration macro: YSYX_23060203_FENCEI_EN
//   defined   : fence.i walks DRAIN -> INV -> REDIR
//   undefined : fencei is ignored, fence.i behaves as a plain flush, and
//               icache_inv_req is constant 0. DRAIN/INV become unreachable
//               and synthesis folds them away.
//
// Ports:
//   clock, reset     clock; synchronous active-high reset
//   cs_flush/cs_dnpc writeback flush pulse and its target PC
//   fencei           marks cs_flush as fence.i
//   br_valid/br_dnpc execute mispredict redirect and its target PC
//   lsu_idle         LSU has no outstanding load/store
//   icache_inv_req   invalidate-all request to the I-cache
//   icache_inv_ack   invalidate-done pulse from the I-cache
//   flush            kill younger work (same cycle as the accepted request)
//   redirect_valid   new fetch PC offered to the IFU
//   redirect_ready   IFU accepts the redirect
//   redirect_pc      new fetch PC (0 when redirect_valid is low)
//   busy             redirect sequence in progress; IFU must not fetch
module ysyx_23060203_csu (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs_flush,
  input  logic [31:0] cs_dnpc,
  input  logic        fencei,
  input  logic        br_valid,
  input  logic [31:0] br_dnpc,
  input  logic        lsu_idle,
  output logic        icache_inv_req,
  input  logic        icache_inv_ack,
  output logic        flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        busy
);

`ifdef YSYX_23060203_FENCEI_EN
  localparam bit FENCEI_EN = 1'b1;
`else
  localparam bit FENCEI_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INV   = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc_r;
  logic        fi_r;
  logic        accept;
  logic        is_fencei;
  logic [31:0] sel_pc;

  // Requests arriving outside IDLE belong to work that is already being
  // killed, so only IDLE accepts. Reset also masks flush, which keeps every
  // output low while reset is held.
  assign accept    = !reset && (state == IDLE) && (cs_flush || br_valid);
  assign is_fencei = FENCEI_EN && cs_flush && fencei;

  // cs_flush comes from an older instruction than br_valid, so it takes
  // priority.
  assign sel_pc = cs_flush ? cs_dnpc : br_dnpc;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // The captured PC is forced to word alignment. The mask is applied to
  // the whole word so that every input bit takes part in the expression.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r <= 32'h0;
      fi_r <= 1'b0;
    end else if (accept) begin
      pc_r <= sel_pc & ~32'h3;
      fi_r <= is_fencei;
    end
  end

  always_comb begin
    next_state     = state;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    icache_inv_req = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        flush = accept;
        if (accept) next_state = is_fencei ? DRAIN : REDIR;
      end
      DRAIN: begin
        // fi_r is always set in this state. It acts as a guard so that a
        // non-fence entry can never fall through into the invalidate.
        if (lsu_idle) next_state = fi_r ? INV : REDIR;
      end
      INV: begin
        icache_inv_req = FENCEI_EN;
        if (icache_inv_ack) next_state = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_r;
        if (redirect_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  // Writeback must not raise another flush while a sequence is running.
  always_ff @(posedge clock) begin
    if (!reset && (state != IDLE) && cs_flush)
      $error("ysyx_23060203_csu: cs_flush while busy (protocol error)");
  end
`endif

endmodule

// File: tb/tb_ysyx_23060203_csu.sv
// tb_ysyx_23060203_csu -- self-checking bench for ysyx_23060203_csu.
//
// Each accepted request pushes its expected redirect PC onto a scoreboard
// queue. The monitor pops an entry on every redirect handshake and compares
// it. Cycle-level output checks sit alongside. Expectations follow
// YSYX_23060203_FENCEI_EN in the same way the design does.
module tb_ysyx_23060203_csu;

  logic        clock;
  logic        reset;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        fencei;
  logic        br_valid;
  logic [31:0] br_dnpc;
  logic        lsu_idle;
  logic        icache_inv_req;
  logic        icache_inv_ack;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int handshakes = 0;
  logic [31:0] exp_q[$];

  ysyx_23060203_csu dut (
    .clock          (clock),
    .reset          (reset),
    .cs_flush       (cs_flush),
    .cs_dnpc        (cs_dnpc),
    .fencei         (fencei),
    .br_valid       (br_valid),
    .br_dnpc        (br_dnpc),
    .lsu_idle       (lsu_idle),
    .icache_inv_req (icache_inv_req),
    .icache_inv_ack (icache_inv_ack),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic fi, input logic [31:0] cs_pc,
                               input logic br, input logic [31:0] br_pc);
    cs_flush = cs;
    fencei   = fi;
    cs_dnpc  = cs_pc;
    br_valid = br;
    br_dnpc  = br_pc;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expectRedirect(input logic [31:0] pc);
    exp_q.push_back(pc);
    pushes++;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_flush"}, {31'b0, flush}, 32'h0);
    checkOutput({tag, "_rv"}, {31'b0, redirect_valid}, 32'h0);
    checkOutput({tag, "_req"}, {31'b0, icache_inv_req}, 32'h0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
    checkOutput({tag, "_pc"}, redirect_pc, 32'h0);
  endtask

  // Scoreboard side: inputs only change just after posedge, so the negedge
  // sees the values the next active edge will sample.
  always @(negedge clock) begin
    if (!reset && redirect_valid && redirect_ready) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected", 32'h1, 32'h0);
      end else begin
        checkOutput("sb_pc", redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset          = 1'b1;
    lsu_idle       = 1'b1;
    icache_inv_ack = 1'b0;
    redirect_ready = 1'b1;
    // A request held during reset must not raise flush.
    applyStimulus(1'b1, 1'b0, 32'h80000010, 1'b0, 32'h0);
    step();
    step();
    checkIdleOutputs("rst");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    step();

    // Plain writeback flush.
    applyStimulus(1'b1, 1'b0, 32'h80000010, 1'b0, 32'h0);
    expectRedirect(32'h80000010);
    #1;
    checkOutput("t1_flush", {31'b0, flush}, 32'h1);
    checkOutput("t1_busy0", {31'b0, busy}, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t1_rv", {31'b0, redirect_valid}, 32'h1);
    checkOutput("t1_pc", redirect_pc, 32'h80000010);
    checkOutput("t1_busy1", {31'b0, busy}, 32'h1);
    checkOutput("t1_noflush", {31'b0, flush}, 32'h0);
    step();
    checkOutput("t1_done_busy", {31'b0, busy}, 32'h0);
    checkOutput("t1_done_pc", redirect_pc, 32'h0);

    // cs_flush and br_valid together: cs_flush wins and the branch is dropped.
    applyStimulus(1'b1, 1'b0, 32'h80000100, 1'b1, 32'h80000200);
    expectRedirect(32'h80000100);
    #1;
    checkOutput("t2_flush", {31'b0, flush}, 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t2_pc", redirect_pc, 32'h80000100);
    step();
    checkOutput("t2_idle", {31'b0, busy}, 32'h0);
    step();
    checkOutput("t2_no_br_redirect", {31'b0, redirect_valid}, 32'h0);

    // Misaligned targets get their low bits cleared.
    applyStimulus(1'b1, 1'b0, 32'h80000013, 1'b0, 32'h0);
    expectRedirect(32'h80000010);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_cs_align", redirect_pc, 32'h80000010);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80000202);
    expectRedirect(32'h80000200);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t5_br_align", redirect_pc, 32'h80000200);
    step();

    // IFU backpressure: the redirect holds steady and extra branches are ignored.
    redirect_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80000300);
    expectRedirect(32'h80000300);
    #1;
    checkOutput("t4_flush", {31'b0, flush}, 32'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80000400);
      #1;
      checkOutput("t4_hold_rv", {31'b0, redirect_valid}, 32'h1);
      checkOutput("t4_hold_pc", redirect_pc, 32'h80000300);
      checkOutput("t4_hold_busy", {31'b0, busy}, 32'h1);
      checkOutput("t4_br_ignored", {31'b0, flush}, 32'h0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    redirect_ready = 1'b1;
    checkOutput("t4_last_pc", redirect_pc, 32'h80000300);
    step();
    checkOutput("t4_idle", {31'b0, busy}, 32'h0);
    step();
    checkOutput("t4_no_extra", {31'b0, redirect_valid}, 32'h0);

    // fence.i with the LSU busy for three cycles and the ack two cycles after req.
    lsu_idle = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h80000040, 1'b0, 32'h0);
    expectRedirect(32'h80000040);
    #1;
    checkOutput("t3_flush", {31'b0, flush}, 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef YSYX_23060203_FENCEI_EN
    for (int i = 0; i < 3; i++) begin
      icache_inv_ack = (i == 0);
      checkOutput("t3_drain_req", {31'b0, icache_inv_req}, 32'h0);
      checkOutput("t3_drain_rv", {31'b0, redirect_valid}, 32'h0);
      checkOutput("t3_drain_busy", {31'b0, busy}, 32'h1);
      step();
    end
    icache_inv_ack = 1'b0;
    lsu_idle = 1'b1;
    checkOutput("t3_drain_last_req", {31'b0, icache_inv_req}, 32'h0);
    step();
    checkOutput("t3_req_rise", {31'b0, icache_inv_req}, 32'h1);
    step();
    checkOutput("t3_req_hold", {31'b0, icache_inv_req}, 32'h1);
    step();
    icache_inv_ack = 1'b1;
    checkOutput("t3_req_at_ack", {31'b0, icache_inv_req}, 32'h1);
    checkOutput("t3_rv_at_ack", {31'b0, redirect_valid}, 32'h0);
    step();
    icache_inv_ack = 1'b0;
    checkOutput("t3_req_drop", {31'b0, icache_inv_req}, 32'h0);
    checkOutput("t3_rv", {31'b0, redirect_valid}, 32'h1);
    checkOutput("t3_pc", redirect_pc, 32'h80000040);
    step();
    checkOutput("t3_idle", {31'b0, busy}, 32'h0);
`else
    checkOutput("t3_plain_req", {31'b0, icache_inv_req}, 32'h0);
    checkOutput("t3_plain_rv", {31'b0, redirect_valid}, 32'h1);
    checkOutput("t3_plain_pc", redirect_pc, 32'h80000040);
    step();
    checkOutput("t3_plain_idle", {31'b0, busy}, 32'h0);
    checkOutput("t3_plain_req2", {31'b0, icache_inv_req}, 32'h0);
    lsu_idle = 1'b1;
`endif
    step();

    // Reset in the middle of a sequence, then a fresh flush.
`ifdef YSYX_23060203_FENCEI_EN
    applyStimulus(1'b1, 1'b1, 32'h80000080, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t6_in_inv", {31'b0, icache_inv_req}, 32'h1);
`else
    redirect_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h80000080, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t6_in_redir", {31'b0, busy}, 32'h1);
`endif
    reset = 1'b1;
    step();
    checkIdleOutputs("t6_rst");
    reset = 1'b0;
    redirect_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h80000500, 1'b0, 32'h0);
    expectRedirect(32'h80000500);
    #1;
    checkOutput("t6_flush", {31'b0, flush}, 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("t6_pc", redirect_pc, 32'h80000500);
    step();
    checkOutput("t6_idle", {31'b0, busy}, 32'h0);
    step();

    checkOutput("sb_empty", exp_q.size(), 32'h0);
    checkOutput("sb_count", handshakes, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
